// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the single data-side Bridge port between the CPU
// MEM-stage data port (master 0) and a secondary requester (master 1).
// Master 0 has fixed priority. A starvation counter bounds how long
// master 1 waits, and a hold counter bounds how long it keeps the bus
// while master 0 waits. One single-cycle transaction per granted cycle.
// Ports:
//   cpu_clk, cpu_rst          clock, synchronous active-low reset
//   m0_req/addr/we/wdata      master 0 request (held until m0_ack)
//   m0_ack, m0_rdata          master 0 acknowledge and read data
//   m1_*                      same as m0_*, for master 1
//   Bus_addr/we/wdata         request fields to the Bridge
//   Bus_rdata                 same-cycle read data from the Bridge
//   owner                     00 IDLE, 01 OWN0, 10 OWN1
module bus_arbiter #(
    parameter int STARVE   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] Bus_addr,
    output logic        Bus_we,
    output logic [31:0] Bus_wdata,
    input  logic [31:0] Bus_rdata,
    output logic [1:0]  owner
);

    localparam int SW = $clog2(STARVE) + 1;
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic        own0, own1;
    logic        starved, hold_done;
    logic        sel_req, sel_we;
    logic [31:0] sel_addr, sel_wdata;

    assign own0   = (state_q == OWN0);
    assign own1   = (state_q == OWN1);
    assign owner  = state_q;
    assign m0_ack = m0_req & own0;
    assign m1_ack = m1_req & own1;

    assign m0_rdata = m0_ack ? Bus_rdata : 32'h0;
    assign m1_rdata = m1_ack ? Bus_rdata : 32'h0;

    always_comb begin
        sel_req   = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        if (own0) begin
            sel_req   = m0_req;
            sel_we    = m0_we;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end else if (own1) begin
            sel_req   = m1_req;
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // An owner that has dropped its request drives nothing onto the bus.
    assign Bus_addr  = sel_req ? sel_addr : 32'h0;
    assign Bus_we    = sel_req & sel_we;
    assign Bus_wdata = sel_req ? sel_wdata : 32'h0;

    always_comb begin
        starve_cnt_d = '0;
        if (m1_req && !m1_ack) begin
            if (starve_cnt_q == STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
        end

        hold_cnt_d = hold_cnt_q;
        if (!own1 || !m0_req) begin
            hold_cnt_d = '0;
        end else if (m1_ack) begin
            if (hold_cnt_q == HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    assign starved = (starve_cnt_q == STARVE_MAX);
    // The hold count includes the current acked cycle, so master 1 gets
    // exactly MAX_HOLD acks while master 0 waits before handing back.
    assign hold_done = (hold_cnt_d == HOLD_MAX);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (m1_req && (!m0_req || starved)) begin
                    state_d = OWN1;
                end else if (m0_req) begin
                    state_d = OWN0;
                end
            end
            OWN0: begin
                if (m1_req && starved) begin
                    state_d = OWN1;
                end else if (!m0_req) begin
                    state_d = m1_req ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (m0_req && hold_done) begin
                    state_d = OWN0;
                end else if (!m1_req) begin
                    state_d = m0_req ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter with a scoreboard queue
// of expected per-cycle outputs derived from the expected owner.
module tb_bus_arbiter;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        m0_req, m0_we, m0_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
    logic        Bus_we;
    logic [1:0]  owner;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [1:0]  own;
        logic        a0;
        logic        a1;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];

    bus_arbiter #(.STARVE(8), .MAX_HOLD(4)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .Bus_addr  (Bus_addr),
        .Bus_we    (Bus_we),
        .Bus_wdata (Bus_wdata),
        .Bus_rdata (Bus_rdata),
        .owner     (owner)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic drv(input logic rst,
                       input logic q0, input logic [31:0] a0,
                       input logic w0, input logic [31:0] d0,
                       input logic q1, input logic [31:0] a1,
                       input logic w1, input logic [31:0] d1,
                       input logic [31:0] rd);
        cpu_rst   = rst;
        m0_req    = q0;
        m0_addr   = a0;
        m0_we     = w0;
        m0_wdata  = d0;
        m1_req    = q1;
        m1_addr   = a1;
        m1_we     = w1;
        m1_wdata  = d1;
        Bus_rdata = rd;
    endtask

    // Build expectation from the current inputs and expected owner, then
    // compare at the falling edge and move on to the next cycle.
    task automatic cyc(input string tag, input logic [1:0] own);
        exp_t e, g;
        e.tag  = tag;
        e.own  = own;
        e.a0   = m0_req && own == 2'b01;
        e.a1   = m1_req && own == 2'b10;
        e.r0   = e.a0 ? Bus_rdata : 32'h0;
        e.r1   = e.a1 ? Bus_rdata : 32'h0;
        e.addr = e.a0 ? m0_addr : (e.a1 ? m1_addr : 32'h0);
        e.we   = e.a0 ? m0_we : (e.a1 ? m1_we : 1'b0);
        e.wd   = e.a0 ? m0_wdata : (e.a1 ? m1_wdata : 32'h0);
        sb.push_back(e);
        @(negedge cpu_clk);
        n_chk++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            g = sb.pop_front();
            chk(g.tag, "owner", {30'h0, owner}, {30'h0, g.own});
            chk(g.tag, "m0_ack", {31'h0, m0_ack}, {31'h0, g.a0});
            chk(g.tag, "m1_ack", {31'h0, m1_ack}, {31'h0, g.a1});
            chk(g.tag, "m0_rdata", m0_rdata, g.r0);
            chk(g.tag, "m1_rdata", m1_rdata, g.r1);
            chk(g.tag, "bus_addr", Bus_addr, g.addr);
            chk(g.tag, "bus_we", {31'h0, Bus_we}, {31'h0, g.we});
            chk(g.tag, "bus_wdata", Bus_wdata, g.wd);
        end
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic skip();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        // reset held with both masters requesting
        drv(0, 1, 32'h0000_0100, 0, 32'h0, 1, 32'h0000_0200, 0, 32'h0, 32'h0);
        skip();
        cyc("rst1", 2'b00);
        cyc("rst2", 2'b00);
        drv(1, 1, 32'h0000_0100, 0, 32'h0, 1, 32'h0000_0200, 0, 32'h0, 32'h11);
        cyc("rst_rel", 2'b00);
        cyc("rst_grant0", 2'b01);
        drv(1, 0, 32'h0000_0100, 0, 32'h0, 0, 32'h0000_0200, 0, 32'h0, 32'h22);
        cyc("drop", 2'b01);
        cyc("idle", 2'b00);

        // lone master 0 read
        drv(1, 1, 32'h8000_0010, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF);
        cyc("rd_req", 2'b00);
        cyc("rd_ack", 2'b01);
        drv(1, 0, 32'h8000_0010, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc("rd_drop", 2'b01);
        cyc("rd_idle", 2'b00);

        // simultaneous fresh requests: master 0 wins
        drv(1, 1, 32'h8000_0020, 1, 32'h1234, 1, 32'h4000_0000, 1,
            32'hA5A5_0001, 32'h33);
        cyc("sim_req", 2'b00);
        cyc("sim_own0", 2'b01);
        drv(1, 1, 32'h8000_0024, 0, 32'h0, 0, 32'h4000_0000, 1,
            32'hA5A5_0001, 32'h44);
        cyc("m1_off", 2'b01);

        // starvation: m1 raised at cycle 0, first ack at cycle 9
        drv(1, 1, 32'h8000_0024, 0, 32'h0, 1, 32'h4000_0000, 1,
            32'hA5A5_0001, 32'h55);
        for (int i = 0; i < 9; i++) cyc("starve_wait", 2'b01);
        cyc("starve_grant", 2'b10);

        // hold limit: 4 consecutive m1 acks, then back to master 0
        for (int i = 0; i < 3; i++) cyc("hold", 2'b10);
        cyc("hold_back", 2'b01);

        // zero-idle handover to master 1 when master 0 drops
        drv(1, 0, 32'h8000_0024, 0, 32'h0, 1, 32'h4000_0008, 1,
            32'hCAFE_0002, 32'h66);
        cyc("hand_m1", 2'b01);
        cyc("m1_write", 2'b10);

        // reset in the middle of a master 1 write
        drv(0, 0, 32'h0, 0, 32'h0, 1, 32'h4000_0008, 1, 32'hCAFE_0002, 32'h77);
        skip();
        drv(1, 0, 32'h0, 0, 32'h0, 1, 32'h4000_0008, 1, 32'hCAFE_0002, 32'h77);
        chk("rst_mid", "starve_cnt", 32'(dut.starve_cnt_q), 32'h0);
        chk("rst_mid", "hold_cnt", 32'(dut.hold_cnt_q), 32'h0);
        cyc("rst_mid", 2'b00);
        cyc("rst_mid_regrant", 2'b10);
        drv(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc("end_drop", 2'b10);
        cyc("end_idle", 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
